piso_serializer: RTL
====================

# piso_serializer

Parallel-in, serial-out serializer: the transmit end of the 4-stage serial-in, parallel-out shift register used in this design. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, MSB first. A receiving shift register clocked on the same clock therefore holds the word in order after WIDTH cycles: `data_in[WIDTH-1]` is in its last stage and `data_in[0]` is in its first. A one-entry holding register lets words stream back-to-back with no idle bit between them.

## Interface
Parameters:
- `WIDTH`, default 4: bits per word. Legal range is WIDTH ≥ 2.
- `IDLE_LEVEL`, default 0: value driven on `serial_out` when no bit is valid.

Ports:
- `clock`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset_n`, input, 1 bit: reset is synchronous and active-low.
- `data_in`, input, WIDTH bits: word to transmit.
- `load_valid`, input, 1 bit: `data_in` is valid.
- `load_ready`, output, 1 bit: the block can accept a word. Equals `!hold_full`.
- `serial_out`, output, 1 bit: serial data, registered.
- `bit_valid`, output, 1 bit: `serial_out` carries a data bit this cycle, registered.
- `last_bit`, output, 1 bit: this cycle carries bit 0 of the current word, registered.

## Operation
- Handshake: a word is accepted on a rising edge where `load_valid && load_ready && reset_n`. `data_in` is sampled only on that edge.
- States (enum): `IDLE`, `SHIFT`.
- **IDLE**:
  - On an accepted word: `shift_reg <= data_in`, `bit_count <= 0`, go to `SHIFT`.
- **SHIFT**, on each edge:
  - `shift_reg` shifts left by one. `serial_out` is always `shift_reg[WIDTH-1]`.
  - `bit_count` increments from 0 to WIDTH-1.
  - An accepted word is written to `hold_reg` and sets `hold_full`.
- **End of word**: on the edge that ends the cycle with `bit_count == WIDTH-1`:
  - If `hold_full`: `shift_reg <= hold_reg`, clear `hold_full`, `bit_count <= 0`, stay in `SHIFT`.
  - Else, if a word is accepted on this same edge: load it directly into `shift_reg`, stay in `SHIFT`.
  - Else: go to `IDLE`.
- `load_ready` cannot be high while `hold_full` is set, so a hold write and a hold drain never coincide with a new load into the hold register.
- In `IDLE` the hold register is always empty.
- `bit_count` width is `$clog2(WIDTH)`. It never wraps past WIDTH-1 and resets to 0 at each word boundary.

## Timing
- Reset values, applied on the first edge with `reset_n` low:
  - state `IDLE`, `shift_reg` = 0, `hold_full` = 0, `bit_count` = 0.
  - `serial_out` = IDLE_LEVEL, `bit_valid` = 0, `last_bit` = 0.
  - `load_ready` = 1 from the first cycle after reset.
- Latency: a word accepted at edge t puts `data_in[WIDTH-1]` on `serial_out` in cycle t+1 and `data_in[0]` in cycle t+WIDTH. `bit_valid` is high for cycles t+1 … t+WIDTH. `last_bit` is high in cycle t+WIDTH.
- Back-to-back: if the next word is held, or is accepted at the end-of-word edge, its MSB appears in cycle t+WIDTH+1. No gap, and `bit_valid` stays high.
- Throughput: one word per WIDTH cycles, sustained.
- `load_ready` behaviour:
  - Falls in the cycle after a word is accepted into the hold register.
  - Rises in the cycle after the hold register drains.
- Whenever `bit_valid` = 0, `serial_out` = IDLE_LEVEL.
- Reset mid-word:
  - The current word and any held word are discarded.
  - Outputs take their reset values on that edge.
  - No `last_bit` is produced for the discarded word.
  - Words presented while `reset_n` is low are not accepted.

## Structure
- Shared package `piso_pkg`: the state typedef `state_t {IDLE, SHIFT}` and the constant `PISO_DEFAULT_WIDTH = 4`.
- One sub-module, `bit_counter`, parameterised by WIDTH.
  - Inputs: `clear` and `enable`.
  - Output: `at_last` when the count equals WIDTH-1.
- The state machine, shift register, and hold register live in `piso_serializer`.

## Test plan
Benches use WIDTH=4 and loop `serial_out` into a 4-stage receiver shift register on the same clock.
- Reset then idle: after reset, `serial_out` = 0, `bit_valid` = 0, `load_ready` = 1. These stay unchanged for 10 cycles with `load_valid` = 0.
- Single word 4'b1011 accepted at edge t: `serial_out` is 1,0,1,1 in cycles t+1..t+4; `last_bit` is high only at t+4. The receiver stages hold 1,1,0,1 (first stage to last), matching `data_in[0..3]`.
- Back-to-back 4'hA, 4'h5 with `load_valid` held high: 8 contiguous valid bits 1010 0101. `load_ready` is low from t+2 until the hold register drains at edge t+4. `last_bit` is high at t+4 and t+8.
- Load on the end-of-word edge with the hold register empty: second word 4'hC is accepted exactly at edge t+4. Its MSB appears at t+5 with no `bit_valid` gap.
- Reset mid-word: word 4'hF is accepted, then `reset_n` is low for one edge at t+2. From that edge `serial_out` = IDLE_LEVEL, `bit_valid` = 0, and the held word is lost. The next accepted word 4'h3 transmits correctly.
- IDLE_LEVEL=1 variant: with the block idle, `serial_out` = 1. Word 4'h0 produces 0,0,0,0, then the line returns to 1.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in, serial-out serializer.
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int PISO_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Per-word bit position counter; flags the final bit of the word for the
// current cycle and for the next cycle.
module bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic at_last,
    output logic at_last_next
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Next count: clear wins, otherwise advance and never run past the last bit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = at_last ? '0 : count_q + CW'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last      = (count_q == LAST);
    assign at_last_next = (count_d == LAST);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with a one-word holding register so words can stream
// back-to-back; all serial-side outputs are registered.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH      = PISO_DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             last_bit
);

    state_t           state_d;
    state_t           state_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] hold_d;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_d;
    logic             hold_full_q;
    logic             serial_d;
    logic             serial_q;
    logic             valid_d;
    logic             valid_q;
    logic             last_d;
    logic             last_q;

    logic             accept;
    logic             cnt_clear;
    logic             cnt_enable;
    logic             at_last;
    logic             at_last_next;

    assign load_ready = !hold_full_q;
    assign accept     = load_valid && load_ready;

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (cnt_clear),
        .enable       (cnt_enable),
        .at_last      (at_last),
        .at_last_next (at_last_next)
    );

    // Next-state, shift and hold register control.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        case (state_q)
            IDLE: begin
                hold_full_d = 1'b0;
                if (accept) begin
                    shift_d   = data_in;
                    cnt_clear = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_clear = 1'b1;
                    // A held word takes priority; load_ready is low then, so no new word competes.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shift_d = data_in;
                    end else begin
                        shift_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    shift_d    = {shift_q[WIDTH-2:0], 1'b0};
                    cnt_enable = 1'b1;
                    if (accept) begin
                        hold_d      = data_in;
                        hold_full_d = 1'b1;
                    end else begin
                        hold_full_d = hold_full_q;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                shift_d     = '0;
                hold_full_d = 1'b0;
                cnt_clear   = 1'b1;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        valid_d  = (state_d == SHIFT);
        serial_d = IDLE_LEVEL;
        last_d   = 1'b0;
        if (valid_d) begin
            serial_d = shift_d[WIDTH-1];
            last_d   = at_last_next;
        end else begin
            serial_d = IDLE_LEVEL;
            last_d   = 1'b0;
        end
    end

    // State, data and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            serial_q    <= IDLE_LEVEL;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            serial_q    <= serial_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign serial_out = serial_q;
    assign bit_valid  = valid_q;
    assign last_bit   = last_q;

endmodule
